// File: rtl/cache_ctrl_pkg.sv
// Shared types for the cache controller: FSM states, way encoding and the
// pmem address-source selector values.
package cache_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COMPARE,
        WRITEBACK,
        ALLOCATE
    } state_e;

    typedef logic way_t;

    localparam logic ADDR_CPU    = 1'b0;
    localparam logic ADDR_VICTIM = 1'b1;

endpackage

// File: rtl/cache_control_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones once there.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/cache_control.sv
// Control FSM for the 2-way, 8-set cache: hit handling, dirty-victim writeback
// and line allocation. Optional performance counters under CACHE_CTRL_PERF_CNT_EN.
module cache_control
    import cache_ctrl_pkg::*;
#(
    parameter int PMEM_TIMEOUT = 255,
    parameter int PERF_W       = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read,
    input  logic              mem_write,
    output logic              mem_resp,
    input  logic              hit0,
    input  logic              hit1,
    input  logic              victim_way,
    input  logic              victim_dirty,
    output logic              lru_load,
    output logic              lru_in,
    output logic              way_sel,
    output logic              data_write,
    output logic              data_load,
    output logic              tag_load,
    output logic              valid_set,
    output logic              dirty_set,
    output logic              dirty_clr,
    output logic              pmem_addr_sel,
    output logic              pmem_read,
    output logic              pmem_write,
    input  logic              pmem_resp,
    output logic              pmem_timeout,
    output logic [PERF_W-1:0] hit_count,
    output logic [PERF_W-1:0] miss_count,
    output logic [PERF_W-1:0] wb_count
);

    localparam int TW = (PMEM_TIMEOUT > 0) ? $clog2(PMEM_TIMEOUT + 1) : 1;

    state_e        state_q, state_d;
    way_t          victim_q, victim_d;
    logic          tmo_q, tmo_d;
    logic          req, hit, waiting, reached;
    way_t          hw;
    logic [TW-1:0] tmo_cnt;

    assign req     = mem_read | mem_write;
    assign hit     = hit0 | hit1;
    assign hw      = hit1 & ~hit0;
    assign waiting = (state_q == WRITEBACK) || (state_q == ALLOCATE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            victim_q <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            victim_q <= victim_d;
            tmo_q    <= tmo_d;
        end
    end

    // Wait-cycle counter restarts whenever the FSM changes state.
    sat_counter #(.W(TW)) u_tmo_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state_d != state_q),
        .inc   (waiting & ~pmem_resp),
        .count (tmo_cnt)
    );

    assign reached      = (PMEM_TIMEOUT != 0) && (tmo_cnt == TW'(PMEM_TIMEOUT));
    assign tmo_d        = tmo_q | reached;
    assign pmem_timeout = tmo_q | reached;

    always_comb begin
        state_d       = state_q;
        victim_d      = victim_q;
        mem_resp      = 1'b0;
        lru_load      = 1'b0;
        lru_in        = 1'b0;
        way_sel       = 1'b0;
        data_write    = 1'b0;
        data_load     = 1'b0;
        tag_load      = 1'b0;
        valid_set     = 1'b0;
        dirty_set     = 1'b0;
        dirty_clr     = 1'b0;
        pmem_addr_sel = ADDR_CPU;
        pmem_read     = 1'b0;
        pmem_write    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req) state_d = COMPARE;
            end
            COMPARE: begin
                if (!req) begin
                    state_d = IDLE;
                end else if (hit) begin
                    mem_resp   = 1'b1;
                    lru_load   = 1'b1;
                    lru_in     = hw;
                    way_sel    = hw;
                    data_write = mem_write;
                    dirty_set  = mem_write;
                    state_d    = IDLE;
                end else begin
                    victim_d = victim_way;
                    state_d  = victim_dirty ? WRITEBACK : ALLOCATE;
                end
            end
            WRITEBACK: begin
                pmem_write    = 1'b1;
                pmem_addr_sel = ADDR_VICTIM;
                way_sel       = victim_q;
                if (pmem_resp) begin
                    dirty_clr = 1'b1;
                    state_d   = ALLOCATE;
                end
            end
            ALLOCATE: begin
                pmem_read     = 1'b1;
                pmem_addr_sel = ADDR_CPU;
                way_sel       = victim_q;
                if (pmem_resp) begin
                    data_load = 1'b1;
                    tag_load  = 1'b1;
                    valid_set = 1'b1;
                    state_d   = COMPARE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    a_single_way_hit: assert property (@(posedge clk) disable iff (!rst_n)
        !((state_q == COMPARE) && req && hit0 && hit1));

`ifdef CACHE_CTRL_PERF_CNT_EN
    logic recheck_q;
    logic in_cmp;

    // The COMPARE right after an allocation is a re-check, not a new hit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            recheck_q <= 1'b0;
        end else begin
            recheck_q <= (state_q == ALLOCATE) && pmem_resp;
        end
    end

    assign in_cmp = (state_q == COMPARE) && req;

    sat_counter #(.W(PERF_W)) u_hit_cnt (
        .clk(clk), .rst_n(rst_n), .clr(1'b0),
        .inc(in_cmp & hit & ~recheck_q), .count(hit_count)
    );
    sat_counter #(.W(PERF_W)) u_miss_cnt (
        .clk(clk), .rst_n(rst_n), .clr(1'b0),
        .inc(in_cmp & ~hit), .count(miss_count)
    );
    sat_counter #(.W(PERF_W)) u_wb_cnt (
        .clk(clk), .rst_n(rst_n), .clr(1'b0),
        .inc((state_q == WRITEBACK) & pmem_resp), .count(wb_count)
    );
`else
    assign hit_count  = '0;
    assign miss_count = '0;
    assign wb_count   = '0;
`endif

endmodule

// File: tb/tb_cache_control.sv
// Self-checking bench for cache_control: table-driven transactions, random
// transactions against a transaction-level model, and reset/timeout/drop corners.
module tb_cache_control;

    localparam int TMO = 4;
    localparam int PW  = 2;
`ifdef CACHE_CTRL_PERF_CNT_EN
    localparam bit PERF_EN = 1'b1;
`else
    localparam bit PERF_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          mem_read = 1'b0, mem_write = 1'b0, mem_resp;
    logic          hit0 = 1'b0, hit1 = 1'b0, victim_way = 1'b0, victim_dirty = 1'b0;
    logic          lru_load, lru_in, way_sel, data_write, data_load, tag_load;
    logic          valid_set, dirty_set, dirty_clr, pmem_addr_sel, pmem_read, pmem_write;
    logic          pmem_resp = 1'b0;
    logic          pmem_timeout;
    logic [PW-1:0] hit_count, miss_count, wb_count;

    cache_control #(.PMEM_TIMEOUT(TMO), .PERF_W(PW)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_read(mem_read), .mem_write(mem_write), .mem_resp(mem_resp),
        .hit0(hit0), .hit1(hit1), .victim_way(victim_way), .victim_dirty(victim_dirty),
        .lru_load(lru_load), .lru_in(lru_in), .way_sel(way_sel),
        .data_write(data_write), .data_load(data_load), .tag_load(tag_load),
        .valid_set(valid_set), .dirty_set(dirty_set), .dirty_clr(dirty_clr),
        .pmem_addr_sel(pmem_addr_sel), .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_resp(pmem_resp), .pmem_timeout(pmem_timeout),
        .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int curLatWb = 1, curLatRd = 1, pmemCnt = 0;
    int nHit = 0, nMiss = 0, nWb = 0;
    bit toExp = 1'b0;

    typedef struct {
        bit rd, wr, h0, h1, vWay, vDirty;
        int latWb, latRd, expLat, expWay;
    } vec_t;
    vec_t vecs[6];

    task automatic checkOutput(input string name, input int act, input int exp);
        total++;
        if (act === exp) passed++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic int satExp(input int n);
        if (!PERF_EN) return 0;
        return (n > (1 << PW) - 1) ? (1 << PW) - 1 : n;
    endfunction

    function automatic int modelLat(input bit h0, input bit h1, input bit d, input int lw, input int lr);
        if (h0 || h1) return 1;
        return 2 + (d ? lw : 0) + lr;
    endfunction

    function automatic int modelWay(input bit h0, input bit h1, input bit v);
        if (h0 || h1) return h0 ? 0 : 1;
        return v;
    endfunction

    // Advance one cycle and act as a pmem that answers after a fixed latency.
    task automatic tick();
        @(posedge clk);
        #1;
        if (pmem_write || pmem_read) begin
            pmemCnt++;
            pmem_resp = (pmemCnt == (pmem_write ? curLatWb : curLatRd));
            if (pmem_resp) pmemCnt = 0;
        end else begin
            pmem_resp = 1'b0;
            pmemCnt   = 0;
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0;
        mem_read = 1'b0; mem_write = 1'b0; hit0 = 1'b0; hit1 = 1'b0; pmem_resp = 1'b0;
        #1;
        checkOutput("resetOutputs", int'({mem_resp, lru_load, lru_in, way_sel, data_write,
            data_load, tag_load, valid_set, dirty_set, dirty_clr, pmem_addr_sel, pmem_read,
            pmem_write, pmem_timeout, hit_count, miss_count, wb_count}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        toExp = 1'b0; nHit = 0; nMiss = 0; nWb = 0; pmemCnt = 0;
    endtask

    task automatic applyStimulus(input bit rd, input bit wr, input bit h0, input bit h1,
                                 input bit vWay, input bit vDirty, input int latWb,
                                 input int latRd, input int expLat, input int expWay,
                                 output int toCyc);
        int respCyc = -1, wrCyc = 0, rdCyc = 0, clrCnt = 0, loadCnt = 0, bad = 0;
        int lruIn = -1, lruLd = -1, wsel = -1, dw = -1, ds = -1;
        bit loaded;
        bit miss = !(h0 || h1);
        toCyc = -1;
        curLatWb = latWb; curLatRd = latRd;
        @(posedge clk);
        #1;
        mem_read = rd; mem_write = wr; hit0 = h0; hit1 = h1;
        victim_way = vWay; victim_dirty = vDirty; pmem_resp = 1'b0;
        for (int cyc = 0; cyc < 100 && respCyc < 0; cyc++) begin
            @(negedge clk);
            loaded = 1'b0;
            if (pmem_timeout && toCyc < 0) toCyc = cyc;
            if (pmem_write) begin
                wrCyc++;
                if (pmem_addr_sel !== 1'b1 || way_sel !== vWay) bad++;
            end
            if (pmem_read) begin
                rdCyc++;
                if (pmem_addr_sel !== 1'b0 || way_sel !== vWay) bad++;
            end
            if (dirty_clr) begin
                clrCnt++;
                if (way_sel !== vWay) bad++;
            end
            if (data_load) begin
                loadCnt++;
                loaded = 1'b1;
                if (!tag_load || !valid_set || way_sel !== vWay) bad++;
            end
            if (mem_resp) begin
                respCyc = cyc;
                lruIn = lru_in; lruLd = lru_load; wsel = way_sel;
                dw = data_write; ds = dirty_set;
            end else begin
                tick();
                if (loaded) begin
                    hit0 = ~vWay;
                    hit1 = vWay;
                end
            end
        end
        @(posedge clk);
        #1;
        mem_read = 1'b0; mem_write = 1'b0; hit0 = 1'b0; hit1 = 1'b0; pmem_resp = 1'b0;
        @(negedge clk);
        if (miss) begin
            nMiss++;
            if (vDirty) nWb++;
            if (vDirty && latWb > TMO) toExp = 1'b1;
            if (latRd > TMO) toExp = 1'b1;
        end else begin
            nHit++;
        end
        checkOutput("respLatency", respCyc, expLat);
        checkOutput("lruIn", lruIn, expWay);
        checkOutput("lruLoad", lruLd, 1);
        checkOutput("waySelAtResp", wsel, expWay);
        checkOutput("dataWrite", dw, int'(wr));
        checkOutput("dirtySet", ds, int'(wr));
        checkOutput("pmemWriteCycles", wrCyc, (miss && vDirty) ? latWb : 0);
        checkOutput("pmemReadCycles", rdCyc, miss ? latRd : 0);
        checkOutput("dirtyClrCount", clrCnt, (miss && vDirty) ? 1 : 0);
        checkOutput("lineLoadCount", loadCnt, miss ? 1 : 0);
        checkOutput("pmemPhaseSignals", bad, 0);
        checkOutput("idleAfterResp", int'(mem_resp), 0);
        checkOutput("timeoutFlag", int'(pmem_timeout), int'(toExp));
        checkOutput("hitCount", int'(hit_count), satExp(nHit));
        checkOutput("missCount", int'(miss_count), satExp(nMiss));
        checkOutput("wbCount", int'(wb_count), satExp(nWb));
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int toCyc, seen, rdc, rsp;
        vecs[0] = '{1, 0, 0, 1, 0, 0, 1, 1, 1, 1};
        vecs[1] = '{0, 1, 1, 0, 1, 1, 1, 1, 1, 0};
        vecs[2] = '{1, 0, 0, 0, 0, 0, 1, 5, 7, 0};
        vecs[3] = '{0, 1, 0, 0, 1, 1, 3, 2, 7, 1};
        vecs[4] = '{1, 1, 0, 0, 0, 1, 1, 1, 4, 0};
        vecs[5] = '{0, 1, 0, 1, 0, 0, 1, 1, 1, 1};

        doReset();
        foreach (vecs[i])
            applyStimulus(vecs[i].rd, vecs[i].wr, vecs[i].h0, vecs[i].h1, vecs[i].vWay,
                          vecs[i].vDirty, vecs[i].latWb, vecs[i].latRd,
                          vecs[i].expLat, vecs[i].expWay, toCyc);

        for (int n = 0; n < 30; n++) begin
            int op = $urandom_range(0, 2);
            int hk = $urandom_range(0, 2);
            bit rd = (op != 1), wr = (op != 0);
            bit h0 = (hk == 1), h1 = (hk == 2);
            bit v = 1'($urandom_range(0, 1)), d = 1'($urandom_range(0, 1));
            int lw = $urandom_range(1, 6), lr = $urandom_range(1, 6);
            applyStimulus(rd, wr, h0, h1, v, d, lw, lr, modelLat(h0, h1, d, lw, lr),
                          modelWay(h0, h1, v), toCyc);
        end

        // Counters: a dirty miss first, so a counted re-check would show up as a hit.
        doReset();
        applyStimulus(0, 1, 0, 0, 1, 1, 2, 2, 6, 1, toCyc);
        for (int n = 0; n < 5; n++) applyStimulus(1, 0, 1, 0, 0, 0, 1, 1, 1, 0, toCyc);
        checkOutput("hitSaturated", int'(hit_count), PERF_EN ? 3 : 0);

        // Timeout: read withheld 10 cycles; flag rises 4 waiting cycles into ALLOCATE.
        doReset();
        applyStimulus(1, 0, 0, 0, 0, 0, 1, 10, 12, 0, toCyc);
        checkOutput("timeoutRiseCycle", toCyc, 6);
        applyStimulus(1, 0, 0, 1, 0, 0, 1, 1, 1, 1, toCyc);

        // Reset asserted mid-ALLOCATE drops pmem_read without a clock edge.
        doReset();
        curLatRd = 1000;
        @(posedge clk);
        #1;
        mem_read = 1'b1; hit0 = 1'b0; hit1 = 1'b0; victim_way = 1'b0; victim_dirty = 1'b0;
        seen = 0;
        for (int c = 0; c < 10 && seen == 0; c++) begin
            @(negedge clk);
            if (pmem_read) seen = 1;
        end
        checkOutput("allocReached", seen, 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rstDropsPmemRead", int'(pmem_read), 0);
        checkOutput("rstNoResp", int'(mem_resp), 0);
        @(negedge clk);
        rst_n = 1'b1; mem_read = 1'b0;
        toExp = 1'b0; nHit = 0; nMiss = 0; nWb = 0; pmemCnt = 0;
        @(negedge clk);
        checkOutput("idleAfterRelease", int'({mem_resp, pmem_read, pmem_write}), 0);
        applyStimulus(1, 0, 0, 1, 0, 0, 1, 1, 1, 1, toCyc);

        // CPU drops its request during ALLOCATE: transfer completes, no response.
        curLatRd = 3;
        @(posedge clk);
        #1;
        mem_read = 1'b1;
        rdc = 0; rsp = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (pmem_read) rdc++;
            if (mem_resp) rsp++;
            tick();
            if (rdc > 0) mem_read = 1'b0;
        end
        nMiss++;
        checkOutput("dropReadCycles", rdc, 3);
        checkOutput("dropNoResp", rsp, 0);
        applyStimulus(0, 1, 1, 0, 0, 0, 1, 1, 1, 0, toCyc);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/cache_control.md
Name: cache_control

Overview:
- Control FSM for the 2-way set-associative, 8-set cache.
- Consumes the per-set victim bit from the LRU array. Produces the LRU update strobe and the way encoding on every hit.
- Sequences writeback of dirty victims and line allocation from physical memory.
- Sits between the CPU memory port, the cache datapath (tag/valid/dirty/data arrays) and the pmem port. Contains no storage arrays.

Parameters:
- PMEM_TIMEOUT, 255: cycles without pmem_resp before the sticky timeout flag sets; 0 disables the check.
- PERF_W, 32: width of the performance counters.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- mem_read  in  1  CPU read request, held until mem_resp
- mem_write  in  1  CPU write request, held until mem_resp
- mem_resp  out  1  one-cycle completion pulse to CPU
- hit0, hit1  in  1 each  tag match and valid, per way, for the current CPU address
- victim_way  in  1  LRU array output for the current set
- victim_dirty  in  1  dirty bit of the victim_way line
- lru_load  out  1  LRU write enable
- lru_in  out  1  way just used (0 = way0, 1 = way1)
- way_sel  out  1  way addressed by the datapath load/write strobes
- data_write  out  1  write CPU data into way_sel line
- data_load  out  1  load pmem line into way_sel
- tag_load  out  1  load tag into way_sel
- valid_set  out  1  set valid of way_sel
- dirty_set  out  1  set dirty of way_sel
- dirty_clr  out  1  clear dirty of way_sel
- pmem_addr_sel  out  1  0 = CPU line address, 1 = victim tag/set address
- pmem_read  out  1  pmem read request, held until pmem_resp
- pmem_write  out  1  pmem write request, held until pmem_resp
- pmem_resp  in  1  pmem completion, one cycle
- pmem_timeout  out  1  sticky timeout flag, cleared only by reset
- hit_count, miss_count, wb_count  out  PERF_W each  performance counters

Behaviour:
- Reset (asynchronous, active-low):
  - State goes to IDLE, the victim register to 0, the timeout counter and flag to 0.
  - Every output is 0, effective immediately; an in-flight pmem request drops mid-transfer.
- States: IDLE, COMPARE, WRITEBACK, ALLOCATE.
- IDLE:
  - All strobes are 0.
  - If mem_read or mem_write is high, go to COMPARE next cycle.
- COMPARE (outputs are combinational from inputs):
  - Request dropped: go to IDLE with no response.
  - Hit, where hw = hit1 & ~hit0:
    - Assert mem_resp, lru_load, lru_in=hw and way_sel=hw.
    - On a write, also assert data_write and dirty_set.
    - Go to IDLE.
  - Hit latency is 2 cycles from request (request seen in IDLE, resp in COMPARE). Back-to-back requests incur one IDLE cycle.
  - Miss: capture victim_way into the victim register. Go to WRITEBACK if victim_dirty, else ALLOCATE. No response this cycle.
- WRITEBACK:
  - Drives pmem_write=1, pmem_addr_sel=1, way_sel=victim.
  - On pmem_resp: assert dirty_clr and go to ALLOCATE.
- ALLOCATE:
  - Drives pmem_read=1, pmem_addr_sel=0, way_sel=victim.
  - On pmem_resp: assert data_load, tag_load and valid_set, then go to COMPARE, which now hits.
  - Miss latency = 2 + pmem latencies + 1 cycles.
- The CPU dropping its request during WRITEBACK/ALLOCATE does not abort the pmem transaction. COMPARE then returns to IDLE with no response.
- hit0 & hit1 together is illegal: way0 wins, and a simulation assertion fires.
- mem_read & mem_write together is illegal: treated as a write.
- Timeout:
  - The counter increments each cycle in WRITEBACK/ALLOCATE without pmem_resp, and clears on state change.
  - When it reaches PMEM_TIMEOUT (nonzero), pmem_timeout sets. The FSM keeps waiting.
  - Counter width is $clog2(PMEM_TIMEOUT+1). The counter saturates.

Optional Feature:
- Macro CACHE_CTRL_PERF_CNT_EN.
- Defined:
  - hit_count increments on each COMPARE hit that is not the post-ALLOCATE re-check.
  - miss_count increments on each COMPARE miss.
  - wb_count increments on each WRITEBACK completion.
  - All counters saturate at all-ones and reset to 0.
- Undefined: the ports remain and are tied to 0; no counter flops are synthesized.

Decomposition:
- Package cache_ctrl_pkg:
  - state enum (IDLE, COMPARE, WRITEBACK, ALLOCATE);
  - way_t (1 bit);
  - pmem_addr_sel encodings ADDR_CPU=0 and ADDR_VICTIM=1.
- One sub-module, sat_counter (parameter W; inputs clk, rst_n, inc; output count): used three times under the macro and reused for the timeout counter.

Test Plan:
- Read hit in way1 (hit1=1): request at cycle 0 -> mem_resp, lru_load=1, lru_in=1 at cycle 1; no pmem activity.
- Clean read miss, victim_way=0, victim_dirty=0, pmem_resp after 5 cycles:
  - pmem_read held 5 cycles, then data_load/tag_load/valid_set with way_sel=0;
  - then a COMPARE hit with mem_resp and lru_in=0.
- Dirty write miss, victim_way=1, victim_dirty=1:
  - pmem_write with pmem_addr_sel=1 until resp, then dirty_clr;
  - then pmem_read with pmem_addr_sel=0;
  - then a hit with data_write, dirty_set, way_sel=1.
- PMEM_TIMEOUT=4 with pmem_resp withheld 10 cycles: pmem_timeout rises after 4 waiting cycles, stays high after resp, and clears only on rst_n.
- rst_n pulled low mid-ALLOCATE: pmem_read drops in the same cycle without a clock edge; state is IDLE after release; no mem_resp.
- With CACHE_CTRL_PERF_CNT_EN and PERF_W=2: 5 hits give hit_count=3 (saturated); 1 dirty miss gives miss_count=1 and wb_count=1.
